// File: rtl/gpu_mem_pkg.sv
// gpu_mem_pkg: definitions shared by the LSU array and the memory arbiter.
// Holds default bus widths, the arbiter FSM state type and the core-state
// encodings the LSU already uses, so both ends agree on a single definition.
package gpu_mem_pkg;
    localparam int ADDR_BITS_DEF = 8;
    localparam int DATA_BITS_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAIT,
        WRITE_WAIT,
        READ_RELAY,
        WRITE_RELAY
    } arb_state_t;

    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;
endpackage

// File: rtl/lsu_mem_arbiter_if.sv
// lsu_mem_arbiter_if: LSU-side request/completion bus plus the single memory channel.
// Ports: consumer_* (per-LSU read/write valid, addr, data, ready, read data; flat
// vectors, slice i = [i*W +: W]) and mem_* (one read and one write channel).
// Modport master is the arbiter; modport slave is the LSUs/memory side.
interface lsu_mem_arbiter_if
    import gpu_mem_pkg::*;
#(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = ADDR_BITS_DEF,
    parameter int DATA_BITS     = DATA_BITS_DEF
);
    logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_addr;
    logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_addr;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_ready;
    logic                               mem_read_valid;
    logic [ADDR_BITS-1:0]               mem_read_addr;
    logic                               mem_read_ready;
    logic [DATA_BITS-1:0]               mem_read_data;
    logic                               mem_write_valid;
    logic [ADDR_BITS-1:0]               mem_write_addr;
    logic [DATA_BITS-1:0]               mem_write_data;
    logic                               mem_write_ready;

    modport master (
        input  consumer_read_valid, consumer_read_addr, consumer_write_valid,
               consumer_write_addr, consumer_write_data,
               mem_read_ready, mem_read_data, mem_write_ready,
        output consumer_read_ready, consumer_read_data, consumer_write_ready,
               mem_read_valid, mem_read_addr, mem_write_valid, mem_write_addr, mem_write_data
    );

    modport slave (
        output consumer_read_valid, consumer_read_addr, consumer_write_valid,
               consumer_write_addr, consumer_write_data,
               mem_read_ready, mem_read_data, mem_write_ready,
        input  consumer_read_ready, consumer_read_data, consumer_write_ready,
               mem_read_valid, mem_read_addr, mem_write_valid, mem_write_addr, mem_write_data
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Ports: req (request vector), ptr (highest-priority index) -> grant (winning
// index), grant_valid (any request present).
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant,
    output logic          grant_valid
);
    logic [IW-1:0] idx;

    // Walk from the far end back to ptr so the candidate closest to ptr is assigned last and wins.
    always_comb begin
        grant = '0;
        grant_valid = 1'b0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                grant = idx;
                grant_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: round-robin arbiter serving LSU read/write requests on one memory channel.
// Ports: clk, reset (synchronous, active-low), bus (lsu_mem_arbiter_if.master).
// One memory transaction is in flight at a time; completion is relayed to the
// granted LSU with a four-phase handshake. All outputs are registered.
module lsu_mem_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = ADDR_BITS_DEF,
    parameter int DATA_BITS     = DATA_BITS_DEF
) (
    input logic clk,
    input logic reset,
    lsu_mem_arbiter_if.master bus
);
    localparam int IW = $clog2(NUM_CONSUMERS);

    arb_state_t state, state_n;
    logic [IW-1:0] g, g_n, rr_ptr, rr_ptr_n, pick;
    logic pick_valid, aborted, aborted_n;
    logic mem_read_valid_n, mem_write_valid_n;
    logic [ADDR_BITS-1:0] mem_read_addr_n, mem_write_addr_n;
    logic [DATA_BITS-1:0] mem_write_data_n;
    logic [NUM_CONSUMERS-1:0] read_ready_n, write_ready_n;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] read_data_n;

    rr_arbiter #(.N(NUM_CONSUMERS)) u_rr (
        .req(bus.consumer_read_valid | bus.consumer_write_valid),
        .ptr(rr_ptr),
        .grant(pick),
        .grant_valid(pick_valid)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            g <= '0;
            rr_ptr <= '0;
            aborted <= 1'b0;
            bus.mem_read_valid <= 1'b0;
            bus.mem_read_addr <= '0;
            bus.mem_write_valid <= 1'b0;
            bus.mem_write_addr <= '0;
            bus.mem_write_data <= '0;
            bus.consumer_read_ready <= '0;
            bus.consumer_read_data <= '0;
            bus.consumer_write_ready <= '0;
        end else begin
            state <= state_n;
            g <= g_n;
            rr_ptr <= rr_ptr_n;
            aborted <= aborted_n;
            bus.mem_read_valid <= mem_read_valid_n;
            bus.mem_read_addr <= mem_read_addr_n;
            bus.mem_write_valid <= mem_write_valid_n;
            bus.mem_write_addr <= mem_write_addr_n;
            bus.mem_write_data <= mem_write_data_n;
            bus.consumer_read_ready <= read_ready_n;
            bus.consumer_read_data <= read_data_n;
            bus.consumer_write_ready <= write_ready_n;
        end
    end

    // aborted remembers that the granted LSU withdrew during the wait, even if it re-asserts later.
    always_comb begin
        state_n = state;
        g_n = g;
        rr_ptr_n = rr_ptr;
        aborted_n = aborted;
        mem_read_valid_n = bus.mem_read_valid;
        mem_read_addr_n = bus.mem_read_addr;
        mem_write_valid_n = bus.mem_write_valid;
        mem_write_addr_n = bus.mem_write_addr;
        mem_write_data_n = bus.mem_write_data;
        read_ready_n = bus.consumer_read_ready;
        read_data_n = bus.consumer_read_data;
        write_ready_n = bus.consumer_write_ready;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    g_n = pick;
                    rr_ptr_n = (pick == IW'(NUM_CONSUMERS - 1)) ? '0 : pick + 1'b1;
                    aborted_n = 1'b0;
                    if (bus.consumer_read_valid[pick]) begin
                        mem_read_valid_n = 1'b1;
                        mem_read_addr_n = bus.consumer_read_addr[pick*ADDR_BITS +: ADDR_BITS];
                        state_n = READ_WAIT;
                    end else begin
                        mem_write_valid_n = 1'b1;
                        mem_write_addr_n = bus.consumer_write_addr[pick*ADDR_BITS +: ADDR_BITS];
                        mem_write_data_n = bus.consumer_write_data[pick*DATA_BITS +: DATA_BITS];
                        state_n = WRITE_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                if (!bus.consumer_read_valid[g]) aborted_n = 1'b1;
                if (bus.mem_read_ready) begin
                    mem_read_valid_n = 1'b0;
                    state_n = aborted_n ? IDLE : READ_RELAY;
                    if (!aborted_n) begin
                        read_data_n[g*DATA_BITS +: DATA_BITS] = bus.mem_read_data;
                        read_ready_n[g] = 1'b1;
                    end
                end
            end
            WRITE_WAIT: begin
                if (!bus.consumer_write_valid[g]) aborted_n = 1'b1;
                if (bus.mem_write_ready) begin
                    mem_write_valid_n = 1'b0;
                    state_n = aborted_n ? IDLE : WRITE_RELAY;
                    if (!aborted_n) write_ready_n[g] = 1'b1;
                end
            end
            READ_RELAY: begin
                if (!bus.consumer_read_valid[g]) begin
                    read_ready_n[g] = 1'b0;
                    state_n = IDLE;
                end
            end
            WRITE_RELAY: begin
                if (!bus.consumer_write_valid[g]) begin
                    write_ready_n[g] = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb_lsu_mem_arbiter: self-checking bench for lsu_mem_arbiter with a memory model and a queue-based ordering model.
module tb_lsu_mem_arbiter;
    localparam int N = 4;

    typedef struct {
        int c;
        bit w;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    lsu_mem_arbiter_if #(.NUM_CONSUMERS(N), .ADDR_BITS(8), .DATA_BITS(8)) bus ();
    lsu_mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(8), .DATA_BITS(8)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    int lat = 0;
    int cnt = 0;
    bit inject = 0;
    int inv_bad = 0;
    bit timed_out;
    int exp_ptr;
    logic [7:0] ra [N];
    logic [7:0] wa [N];
    logic [7:0] wd [N];
    txn_t mem_log[$];
    txn_t obs[$];
    txn_t exp_q[$];

    // Memory: acknowledges after lat idle cycles, one outstanding request.
    always @(negedge clk) begin
        bus.mem_read_ready = 1'b0;
        bus.mem_write_ready = 1'b0;
        if (inject) begin
            bus.mem_read_ready = 1'b1;
            bus.mem_write_ready = 1'b1;
            bus.mem_read_data = 8'hA5;
        end else if (bus.mem_read_valid) begin
            if (cnt >= lat) begin
                bus.mem_read_ready = 1'b1;
                bus.mem_read_data = mem[bus.mem_read_addr];
                mem_log.push_back('{-1, 1'b0, bus.mem_read_addr, mem[bus.mem_read_addr]});
                cnt = 0;
            end else cnt++;
        end else if (bus.mem_write_valid) begin
            if (cnt >= lat) begin
                bus.mem_write_ready = 1'b1;
                mem[bus.mem_write_addr] = bus.mem_write_data;
                mem_log.push_back('{-1, 1'b1, bus.mem_write_addr, bus.mem_write_data});
                cnt = 0;
            end else cnt++;
        end else cnt = 0;
    end

    always @(negedge clk) begin
        if (reset) begin
            if (bus.mem_read_valid && bus.mem_write_valid) inv_bad++;
            if ($countones({bus.consumer_read_ready, bus.consumer_write_ready}) > 1) inv_bad++;
        end
    end

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        bus.consumer_read_valid = '0;
        bus.consumer_write_valid = '0;
        cycle();
        reset = 1'b1;
    endtask

    // LSU behaviour: raise the given requests, drop each valid once its ready is seen.
    task automatic run_batch(input logic [N-1:0] rd, input logic [N-1:0] wr, input int budget);
        obs.delete();
        mem_log.delete();
        timed_out = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.consumer_read_addr[i*8 +: 8] = ra[i];
            bus.consumer_write_addr[i*8 +: 8] = wa[i];
            bus.consumer_write_data[i*8 +: 8] = wd[i];
        end
        bus.consumer_read_valid = rd;
        bus.consumer_write_valid = wr;
        for (int n = 0; n < budget; n++) begin
            cycle();
            for (int i = 0; i < N; i++) begin
                if (bus.consumer_read_ready[i] && bus.consumer_read_valid[i]) begin
                    obs.push_back('{i, 1'b0, ra[i], bus.consumer_read_data[i*8 +: 8]});
                    bus.consumer_read_valid[i] = 1'b0;
                end
                if (bus.consumer_write_ready[i] && bus.consumer_write_valid[i]) begin
                    obs.push_back('{i, 1'b1, wa[i], wd[i]});
                    bus.consumer_write_valid[i] = 1'b0;
                end
            end
            if (bus.consumer_read_valid == '0 && bus.consumer_write_valid == '0 &&
                bus.consumer_read_ready == '0 && bus.consumer_write_ready == '0) return;
        end
        timed_out = 1'b1;
        bus.consumer_read_valid = '0;
        bus.consumer_write_valid = '0;
    endtask

    // Reference: pending ops per LSU, pick the first LSU at/after the pointer, read before write.
    task automatic predict(input logic [N-1:0] rd, input logic [N-1:0] wr);
        logic [N-1:0] pr, pw;
        int c;
        pr = rd;
        pw = wr;
        exp_q.delete();
        while ((pr | pw) != '0) begin
            for (int k = 0; k < N; k++) begin
                c = (exp_ptr + k) % N;
                if (pr[c] || pw[c]) begin
                    if (pr[c]) begin
                        exp_q.push_back('{c, 1'b0, ra[c], ref_mem[ra[c]]});
                        pr[c] = 1'b0;
                    end else begin
                        exp_q.push_back('{c, 1'b1, wa[c], wd[c]});
                        ref_mem[wa[c]] = wd[c];
                        pw[c] = 1'b0;
                    end
                    exp_ptr = (c + 1) % N;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.mem_read_valid, bus.mem_write_valid} !== 2'b00) begin
            failures++;
            $display("FAIL reset_mem_valid got=%b%b want=00", bus.mem_read_valid, bus.mem_write_valid);
        end
        checks++;
        if ({bus.consumer_read_ready, bus.consumer_write_ready} !== '0) begin
            failures++;
            $display("FAIL reset_ready got=%h want=0", {bus.consumer_read_ready, bus.consumer_write_ready});
        end
        checks++;
        if ({bus.consumer_read_data, bus.mem_read_addr, bus.mem_write_addr, bus.mem_write_data} !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h want=0", {bus.consumer_read_data, bus.mem_read_addr, bus.mem_write_addr, bus.mem_write_data});
        end
        reset = 1'b1;
    endtask

    task automatic test_single_read();
        int n;
        lat = 3;
        mem[8'h2A] = 8'h5C;
        bus.consumer_read_addr[8 +: 8] = 8'h2A;
        bus.consumer_read_valid[1] = 1'b1;
        cycle();
        checks++;
        if (bus.mem_read_valid !== 1'b1 || bus.mem_read_addr !== 8'h2A) begin
            failures++;
            $display("FAIL read_issue got valid=%b addr=%h want valid=1 addr=2a", bus.mem_read_valid, bus.mem_read_addr);
        end
        n = 1;
        while (bus.consumer_read_ready[1] !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        checks++;
        if (n != lat + 2) begin
            failures++;
            $display("FAIL read_latency got=%0d want=%0d", n, lat + 2);
        end
        checks++;
        if (bus.consumer_read_data[8 +: 8] !== 8'h5C || bus.mem_read_valid !== 1'b0) begin
            failures++;
            $display("FAIL read_data got=%h mrv=%b want=5c mrv=0", bus.consumer_read_data[8 +: 8], bus.mem_read_valid);
        end
        cycle();
        checks++;
        if (bus.consumer_read_ready[1] !== 1'b1) begin
            failures++;
            $display("FAIL read_hold got=%b want=1", bus.consumer_read_ready[1]);
        end
        bus.consumer_read_valid[1] = 1'b0;
        cycle();
        checks++;
        if (bus.consumer_read_ready !== '0) begin
            failures++;
            $display("FAIL read_release got=%b want=0", bus.consumer_read_ready);
        end
    endtask

    task automatic test_single_write();
        int n;
        lat = 1;
        bus.consumer_write_addr[16 +: 8] = 8'h10;
        bus.consumer_write_data[16 +: 8] = 8'hEE;
        bus.consumer_write_valid[2] = 1'b1;
        cycle();
        checks++;
        if (bus.mem_write_valid !== 1'b1 || bus.mem_write_addr !== 8'h10 || bus.mem_write_data !== 8'hEE || bus.mem_read_valid !== 1'b0) begin
            failures++;
            $display("FAIL write_issue got v=%b a=%h d=%h want v=1 a=10 d=ee", bus.mem_write_valid, bus.mem_write_addr, bus.mem_write_data);
        end
        n = 1;
        while (bus.consumer_write_ready[2] !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        checks++;
        if (n != lat + 2) begin
            failures++;
            $display("FAIL write_latency got=%0d want=%0d", n, lat + 2);
        end
        checks++;
        if (mem[8'h10] !== 8'hEE) begin
            failures++;
            $display("FAIL write_mem got=%h want=ee", mem[8'h10]);
        end
        repeat (2) cycle();
        checks++;
        if (bus.consumer_write_ready !== 4'b0100) begin
            failures++;
            $display("FAIL write_hold got=%b want=0100", bus.consumer_write_ready);
        end
        bus.consumer_write_valid[2] = 1'b0;
        cycle();
        checks++;
        if (bus.consumer_write_ready !== '0) begin
            failures++;
            $display("FAIL write_release got=%b want=0", bus.consumer_write_ready);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int b = 0; b < 2; b++) begin
            lat = b;
            for (int i = 0; i < N; i++) begin
                ra[i] = 8'(i);
                mem[i] = 8'(8'h30 + 16 * b + i);
            end
            run_batch(4'hF, 4'h0, 100);
            checks++;
            if (timed_out || obs.size() != N) begin
                failures++;
                $display("FAIL rr_batch%0d_count got=%0d timeout=%b want=%0d", b, obs.size(), timed_out, N);
            end else begin
                for (int i = 0; i < N; i++) begin
                    checks++;
                    if (obs[i].c != i || obs[i].data !== 8'(8'h30 + 16 * b + i)) begin
                        failures++;
                        $display("FAIL rr_batch%0d_slot%0d got=c%0d/%h want=c%0d/%h", b, i, obs[i].c, obs[i].data, i, 8'(8'h30 + 16 * b + i));
                    end
                end
            end
        end
    endtask

    task automatic test_read_write();
        lat = 1;
        ra[0] = 8'h04;
        wa[0] = 8'h08;
        wd[0] = 8'h77;
        mem[8'h04] = 8'h99;
        run_batch(4'b0001, 4'b0001, 50);
        checks++;
        if (timed_out || obs.size() != 2 || mem_log.size() != 2) begin
            failures++;
            $display("FAIL rw_count got=%0d/%0d timeout=%b want=2/2", obs.size(), mem_log.size(), timed_out);
        end else begin
            checks++;
            if (obs[0].w || obs[0].data !== 8'h99 || mem_log[0].w || mem_log[0].addr !== 8'h04) begin
                failures++;
                $display("FAIL rw_first got=w%0d/%h mem=w%0d/%h want=w0/99 mem=w0/04", obs[0].w, obs[0].data, mem_log[0].w, mem_log[0].addr);
            end
            checks++;
            if (!obs[1].w || !mem_log[1].w || mem_log[1].addr !== 8'h08 || mem[8'h08] !== 8'h77) begin
                failures++;
                $display("FAIL rw_second got=w%0d addr=%h mem=%h want=w1 addr=08 mem=77", mem_log[1].w, mem_log[1].addr, mem[8'h08]);
            end
        end
    endtask

    task automatic test_abort();
        bit saw_ready;
        int n;
        lat = 4;
        mem_log.delete();
        bus.consumer_read_addr[24 +: 8] = 8'h33;
        bus.consumer_read_valid[3] = 1'b1;
        cycle();
        checks++;
        if (bus.mem_read_valid !== 1'b1 || bus.mem_read_addr !== 8'h33) begin
            failures++;
            $display("FAIL abort_issue got v=%b a=%h want v=1 a=33", bus.mem_read_valid, bus.mem_read_addr);
        end
        cycle();
        bus.consumer_read_valid[3] = 1'b0;
        saw_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            saw_ready |= bus.consumer_read_ready[3];
        end
        checks++;
        if (mem_log.size() != 1 || saw_ready || bus.mem_read_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort got memtxns=%0d ready=%b mrv=%b want memtxns=1 ready=0 mrv=0", mem_log.size(), saw_ready, bus.mem_read_valid);
        end
        lat = 0;
        mem[8'h01] = 8'h3C;
        bus.consumer_read_addr[0 +: 8] = 8'h01;
        bus.consumer_read_valid[0] = 1'b1;
        n = 0;
        while (bus.consumer_read_ready[0] !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        checks++;
        if (n != 2 || bus.consumer_read_data[7:0] !== 8'h3C) begin
            failures++;
            $display("FAIL abort_recover got cycles=%0d data=%h want cycles=2 data=3c", n, bus.consumer_read_data[7:0]);
        end
        bus.consumer_read_valid[0] = 1'b0;
        cycle();
    endtask

    task automatic test_spurious();
        bit bad;
        bad = 1'b0;
        @(posedge clk);
        inject = 1'b1;
        @(posedge clk);
        inject = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if ({bus.consumer_read_ready, bus.consumer_write_ready, bus.mem_read_valid, bus.mem_write_valid} !== '0) bad = 1'b1;
            if (k < 2) @(posedge clk);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL spurious_ready got outputs active want idle");
        end
    endtask

    task automatic test_reset_mid();
        lat = 10;
        bus.consumer_read_addr[8 +: 8] = 8'h2A;
        bus.consumer_read_valid[1] = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
        bus.consumer_read_valid = '0;
        cycle();
        checks++;
        if ({bus.mem_read_valid, bus.mem_write_valid, bus.consumer_read_ready, bus.consumer_write_ready, bus.consumer_read_data, bus.mem_read_addr} !== '0) begin
            failures++;
            $display("FAIL reset_mid got mrv=%b crd=%h want all 0", bus.mem_read_valid, bus.consumer_read_data);
        end
        reset = 1'b1;
        lat = 1;
        ra[0] = 8'h50;
        ra[2] = 8'h52;
        mem[8'h50] = 8'h05;
        mem[8'h52] = 8'h25;
        run_batch(4'b0101, 4'b0000, 60);
        checks++;
        if (timed_out || obs.size() != 2 || obs[0].c != 0 || obs[1].c != 2 || obs[1].data !== 8'h25) begin
            failures++;
            $display("FAIL reset_mid_after got count=%0d timeout=%b want order c0,c2 data 25", obs.size(), timed_out);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] rd, wr;
        apply_reset();
        exp_ptr = 0;
        for (int a = 0; a < 256; a++) ref_mem[a] = mem[a];
        for (int it = 0; it < 25; it++) begin
            rd = 4'($urandom_range(0, 15));
            wr = 4'($urandom_range(0, 15));
            if ((rd | wr) == '0) rd = 4'b0001;
            lat = $urandom_range(0, 3);
            for (int i = 0; i < N; i++) begin
                ra[i] = 8'($urandom);
                wa[i] = 8'($urandom);
                wd[i] = 8'($urandom);
            end
            predict(rd, wr);
            run_batch(rd, wr, 300);
            checks++;
            if (timed_out || obs.size() != exp_q.size() || mem_log.size() != exp_q.size()) begin
                failures++;
                $display("FAIL rand%0d_count got=%0d/%0d timeout=%b want=%0d", it, obs.size(), mem_log.size(), timed_out, exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++;
                    if (obs[i].c != exp_q[i].c || obs[i].w != exp_q[i].w || obs[i].data !== exp_q[i].data ||
                        mem_log[i].w != exp_q[i].w || mem_log[i].addr !== exp_q[i].addr) begin
                        failures++;
                        $display("FAIL rand%0d_txn%0d got=c%0d w%0d d=%h a=%h want=c%0d w%0d d=%h a=%h", it, i,
                                 obs[i].c, obs[i].w, obs[i].data, mem_log[i].addr, exp_q[i].c, exp_q[i].w, exp_q[i].data, exp_q[i].addr);
                    end
                end
            end
        end
        checks++;
        if (inv_bad != 0) begin
            failures++;
            $display("FAIL invariants got=%0d violations want=0", inv_bad);
        end
    endtask

    initial begin
        bus.consumer_read_valid = '0;
        bus.consumer_read_addr = '0;
        bus.consumer_write_valid = '0;
        bus.consumer_write_addr = '0;
        bus.consumer_write_data = '0;
        bus.mem_read_ready = 1'b0;
        bus.mem_read_data = '0;
        bus.mem_write_ready = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        test_reset();
        test_single_read();
        test_single_write();
        test_round_robin();
        test_read_write();
        test_abort();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
